// File: rtl/adt7420_pkg.sv
// Shared definitions for the ADT7420 temperature sample processing path:
// default widths, FSM state encodings and the min/max preset constants.
package adt7420_pkg;

  localparam int TW_DEFAULT       = 13;
  localparam int WIN_LOG2_DEFAULT = 3;

  // Min starts at the most positive value and max at the most negative one,
  // so any real reading immediately replaces both.
  localparam logic [12:0] MIN_INIT = 13'h0FFF;
  localparam logic [12:0] MAX_INIT = 13'h1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2,
    REPORT  = 2'd3
  } state_t;

endpackage

// File: rtl/temp_window_buf.sv
// Circular averaging window: 2^WIN_LOG2 temperature words, a wrapping write
// pointer, and a read port that shows the entry about to be overwritten.
import adt7420_pkg::*;

module temp_window_buf #(
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT,
  parameter int TW       = TW_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_wrEn,
  input  logic signed [TW-1:0] i_wrData,
  output logic signed [TW-1:0] o_oldest
);

  localparam int DEPTH = 1 << WIN_LOG2;

  logic signed [TW-1:0] r_entries [DEPTH];
  logic [WIN_LOG2-1:0]  r_wrPtr;

  // Entries are zeroed on reset/clear so a partly filled window averages in zeros;
  // the pointer wraps naturally because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_wrPtr <= '0;
    end else if (i_wrEn) begin
      r_entries[r_wrPtr] <= i_wrData;
      r_wrPtr            <= r_wrPtr + WIN_LOG2'(1);
    end
  end

  assign o_oldest = r_entries[r_wrPtr];

endmodule

// File: rtl/temp_sample_proc.sv
// Temperature sample processor: converts raw sensor bytes, keeps a running
// window average, min/max, a saturating sample count, an over-temperature
// alarm with hysteresis and a sticky overrun flag for dropped samples.
import adt7420_pkg::*;

module temp_sample_proc #(
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT,
  parameter int TW       = TW_DEFAULT
) (
  input  logic                 FSM_Clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [7:0]           temp_msb,
  input  logic [7:0]           temp_lsb,
  input  logic                 clear_stats,
  input  logic signed [TW-1:0] alarm_thr,
  input  logic [7:0]           alarm_hyst,
  output logic signed [TW-1:0] temp_cur,
  output logic signed [TW-1:0] temp_avg,
  output logic signed [TW-1:0] temp_min,
  output logic signed [TW-1:0] temp_max,
  output logic                 out_valid,
  output logic                 avg_valid,
  output logic                 alarm,
  output logic                 overrun,
  output logic [15:0]          sample_count
);

  localparam int          SW          = TW + WIN_LOG2;
  localparam int          AW          = TW + 2;
  localparam logic [15:0] WIN_DEPTH16 = 16'(1 << WIN_LOG2);

  state_t               r_state;
  logic [7:0]           r_rawMsb;
  logic [4:0]           r_rawLsbHi;
  logic signed [TW-1:0] r_tempCur;
  logic signed [TW-1:0] r_tempAvg;
  logic signed [TW-1:0] r_tempMin;
  logic signed [TW-1:0] r_tempMax;
  logic signed [SW-1:0] r_sum;
  logic                 r_outValid;
  logic                 r_avgValid;
  logic                 r_alarm;
  logic                 r_overrun;
  logic [15:0]          r_sampleCount;

  logic signed [TW-1:0] w_oldest;
  logic signed [SW-1:0] w_sumNext;
  logic signed [AW-1:0] w_curExt;
  logic signed [AW-1:0] w_thrExt;
  logic signed [AW-1:0] w_hystExt;
  logic signed [AW-1:0] w_clrLevel;
  logic [15:0]          w_countNext;
  logic                 w_winWrite;
  logic                 w_unusedLsbBits;

  // The three low LSB bits are sensor status flags and carry no temperature.
  assign w_unusedLsbBits = ^temp_lsb[2:0];

  assign w_winWrite  = (r_state == UPDATE) && !clear_stats;
  assign w_sumNext   = r_sum + SW'(r_tempCur) - SW'(w_oldest);
  assign w_countNext = (r_sampleCount == 16'hFFFF) ? r_sampleCount : r_sampleCount + 16'd1;

  // Release level is formed two bits wider so threshold minus hysteresis cannot wrap.
  assign w_curExt   = AW'(r_tempCur);
  assign w_thrExt   = AW'(alarm_thr);
  assign w_hystExt  = AW'({1'b0, alarm_hyst});
  assign w_clrLevel = w_thrExt - w_hystExt;

  temp_window_buf #(
    .WIN_LOG2 (WIN_LOG2),
    .TW       (TW)
  ) u_window (
    .clock    (FSM_Clk),
    .reset    (reset),
    .i_clear  (clear_stats),
    .i_wrEn   (w_winWrite),
    .i_wrData (r_tempCur),
    .o_oldest (w_oldest)
  );

  // Sample FSM: IDLE accepts a read, CONVERT forms the word, UPDATE folds it into
  // the statistics and raises out_valid so every output is fresh during REPORT.
  always_ff @(posedge FSM_Clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rawMsb      <= '0;
      r_rawLsbHi    <= '0;
      r_tempCur     <= '0;
      r_tempAvg     <= '0;
      r_tempMin     <= TW'(MIN_INIT);
      r_tempMax     <= TW'(MAX_INIT);
      r_sum         <= '0;
      r_outValid    <= 1'b0;
      r_avgValid    <= 1'b0;
      r_alarm       <= 1'b0;
      r_overrun     <= 1'b0;
      r_sampleCount <= '0;
    end else if (clear_stats) begin
      r_state       <= IDLE;
      r_tempMin     <= TW'(MIN_INIT);
      r_tempMax     <= TW'(MAX_INIT);
      r_sum         <= '0;
      r_outValid    <= 1'b0;
      r_avgValid    <= 1'b0;
      r_overrun     <= 1'b0;
      r_sampleCount <= '0;
    end else begin
      r_outValid <= 1'b0;
      if (sample_valid && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (sample_valid) begin
            r_rawMsb   <= temp_msb;
            r_rawLsbHi <= temp_lsb[7:3];
            r_state    <= CONVERT;
          end
        end
        CONVERT: begin
          r_tempCur <= TW'({r_rawMsb, r_rawLsbHi});
          r_state   <= UPDATE;
        end
        UPDATE: begin
          r_sum     <= w_sumNext;
          r_tempAvg <= TW'(w_sumNext >>> WIN_LOG2);
          if (r_sampleCount == 16'd0) begin
            r_tempMin <= r_tempCur;
            r_tempMax <= r_tempCur;
          end else begin
            if (r_tempCur < r_tempMin) r_tempMin <= r_tempCur;
            if (r_tempCur > r_tempMax) r_tempMax <= r_tempCur;
          end
          r_sampleCount <= w_countNext;
          if (w_countNext >= WIN_DEPTH16) r_avgValid <= 1'b1;
          if (r_tempCur >= alarm_thr) begin
            r_alarm <= 1'b1;
          end else if (w_curExt < w_clrLevel) begin
            r_alarm <= 1'b0;
          end
          r_outValid <= 1'b1;
          r_state    <= REPORT;
        end
        REPORT: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign temp_cur     = r_tempCur;
  assign temp_avg     = r_tempAvg;
  assign temp_min     = r_tempMin;
  assign temp_max     = r_tempMax;
  assign out_valid    = r_outValid;
  assign avg_valid    = r_avgValid;
  assign alarm        = r_alarm;
  assign overrun      = r_overrun;
  assign sample_count = r_sampleCount;

endmodule

// File: tb/tb_temp_sample_proc.sv
// Directed testbench for temp_sample_proc: conversion, latency, averaging,
// alarm hysteresis, overrun, clear behaviour and reset mid-sample.
module tb_temp_sample_proc;

  logic        FSM_Clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [7:0]  temp_msb;
  logic [7:0]  temp_lsb;
  logic        clear_stats;
  logic [12:0] alarm_thr;
  logic [7:0]  alarm_hyst;
  logic [12:0] temp_cur;
  logic [12:0] temp_avg;
  logic [12:0] temp_min;
  logic [12:0] temp_max;
  logic        out_valid;
  logic        avg_valid;
  logic        alarm;
  logic        overrun;
  logic [15:0] sample_count;

  int testsRun    = 0;
  int testsFailed = 0;

  temp_sample_proc dut (
    .FSM_Clk      (FSM_Clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .temp_msb     (temp_msb),
    .temp_lsb     (temp_lsb),
    .clear_stats  (clear_stats),
    .alarm_thr    (alarm_thr),
    .alarm_hyst   (alarm_hyst),
    .temp_cur     (temp_cur),
    .temp_avg     (temp_avg),
    .temp_min     (temp_min),
    .temp_max     (temp_max),
    .out_valid    (out_valid),
    .avg_valid    (avg_valid),
    .alarm        (alarm),
    .overrun      (overrun),
    .sample_count (sample_count)
  );

  // 100 MHz clock.
  always #5 FSM_Clk = ~FSM_Clk;

  // Hard stop in case something wedges the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just past the edge.
  task automatic stepCycle();
    @(posedge FSM_Clk);
    #1;
  endtask

  // Drive one sample strobe, count edges until out_valid (bounded), then
  // step once more so the FSM is back in IDLE when this returns.
  task automatic applyStimulus(input logic [7:0] msb, input logic [7:0] lsb,
                               output int latency, output logic avgAtPulse);
    latency    = -1;
    avgAtPulse = 1'b0;
    temp_msb     = msb;
    temp_lsb     = lsb;
    sample_valid = 1'b1;
    stepCycle();
    sample_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) stepCycle();
      if (out_valid === 1'b1) begin
        latency    = k;
        avgAtPulse = avg_valid;
        break;
      end
    end
    stepCycle();
  endtask

  task automatic pulseClear();
    clear_stats = 1'b1;
    stepCycle();
    clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    testsRun++; if (temp_cur !== 13'd0) begin testsFailed++; $display("[TB] FAIL reset_temp_cur got %h want 0", temp_cur); end
    testsRun++; if (temp_avg !== 13'd0) begin testsFailed++; $display("[TB] FAIL reset_temp_avg got %h want 0", temp_avg); end
    testsRun++; if (temp_min !== 13'h0FFF) begin testsFailed++; $display("[TB] FAIL reset_temp_min got %h want 0FFF", temp_min); end
    testsRun++; if (temp_max !== 13'h1000) begin testsFailed++; $display("[TB] FAIL reset_temp_max got %h want 1000", temp_max); end
    testsRun++; if ({out_valid, avg_valid, alarm, overrun} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_flags got %b want 0000", {out_valid, avg_valid, alarm, overrun}); end
    testsRun++; if (sample_count !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_count got %0d want 0", sample_count); end
  endtask

  task automatic test_conversion();
    int   lat;
    logic av;
    applyStimulus(8'h0C, 8'h80, lat, av);
    testsRun++; if (lat !== 3) begin testsFailed++; $display("[TB] FAIL conv_latency got %0d want 3", lat); end
    testsRun++; if (temp_cur !== 13'd400) begin testsFailed++; $display("[TB] FAIL conv_temp_cur got %0d want 400", temp_cur); end
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL conv_pulse_width got %b want 0", out_valid); end
    testsRun++; if (sample_count !== 16'd1) begin testsFailed++; $display("[TB] FAIL conv_count got %0d want 1", sample_count); end
    testsRun++; if ((temp_min !== 13'd400) || (temp_max !== 13'd400)) begin testsFailed++; $display("[TB] FAIL conv_minmax got %0d/%0d want 400/400", temp_min, temp_max); end
  endtask

  task automatic test_negative();
    int   lat;
    logic av;
    applyStimulus(8'hE7, 8'h07, lat, av);
    testsRun++; if (lat !== 3) begin testsFailed++; $display("[TB] FAIL neg_latency got %0d want 3", lat); end
    testsRun++; if (temp_cur !== 13'h1CE0) begin testsFailed++; $display("[TB] FAIL neg_temp_cur got %h want 1CE0", temp_cur); end
    testsRun++; if (temp_min !== 13'h1CE0) begin testsFailed++; $display("[TB] FAIL neg_temp_min got %h want 1CE0", temp_min); end
    testsRun++; if (temp_max !== 13'd400) begin testsFailed++; $display("[TB] FAIL neg_temp_max got %0d want 400", temp_max); end
    testsRun++; if (sample_count !== 16'd2) begin testsFailed++; $display("[TB] FAIL neg_count got %0d want 2", sample_count); end
  endtask

  task automatic test_average();
    int   lat;
    logic av;
    pulseClear();
    testsRun++; if (sample_count !== 16'd0) begin testsFailed++; $display("[TB] FAIL avg_clear_count got %0d want 0", sample_count); end
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(8'h0C, 8'h80, lat, av);
      if (i == 1) begin
        testsRun++; if (temp_avg !== 13'd50) begin testsFailed++; $display("[TB] FAIL avg_first got %0d want 50", temp_avg); end
      end
      if (i == 7) begin
        testsRun++; if ((avg_valid !== 1'b0) || (temp_avg !== 13'd350)) begin testsFailed++; $display("[TB] FAIL avg_seventh got valid=%b avg=%0d want 0/350", avg_valid, temp_avg); end
      end
      if (i == 8) begin
        testsRun++; if (av !== 1'b1) begin testsFailed++; $display("[TB] FAIL avg_valid_at_pulse got %b want 1", av); end
        testsRun++; if (temp_avg !== 13'd400) begin testsFailed++; $display("[TB] FAIL avg_eighth got %0d want 400", temp_avg); end
      end
    end
    applyStimulus(8'h0F, 8'h00, lat, av);
    testsRun++; if (temp_avg !== 13'd410) begin testsFailed++; $display("[TB] FAIL avg_ninth got %0d want 410", temp_avg); end
    testsRun++; if (avg_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL avg_valid_hold got %b want 1", avg_valid); end
  endtask

  task automatic test_alarm();
    int   lat;
    logic av;
    alarm_thr  = 13'd480;
    alarm_hyst = 8'd16;
    applyStimulus(8'h0F, 8'h00, lat, av);
    testsRun++; if (alarm !== 1'b1) begin testsFailed++; $display("[TB] FAIL alarm_480 got %b want 1", alarm); end
    applyStimulus(8'h0E, 8'hB0, lat, av);
    testsRun++; if (temp_cur !== 13'd470) begin testsFailed++; $display("[TB] FAIL alarm_cur_470 got %0d want 470", temp_cur); end
    testsRun++; if (alarm !== 1'b1) begin testsFailed++; $display("[TB] FAIL alarm_470 got %b want 1", alarm); end
    pulseClear();
    testsRun++; if ((alarm !== 1'b1) || (temp_cur !== 13'd470)) begin testsFailed++; $display("[TB] FAIL alarm_kept_on_clear got %b/%0d want 1/470", alarm, temp_cur); end
    applyStimulus(8'h0E, 8'h78, lat, av);
    testsRun++; if (temp_cur !== 13'd463) begin testsFailed++; $display("[TB] FAIL alarm_cur_463 got %0d want 463", temp_cur); end
    testsRun++; if (alarm !== 1'b0) begin testsFailed++; $display("[TB] FAIL alarm_463 got %b want 0", alarm); end
  endtask

  task automatic test_overrun();
    int pulses;
    pulseClear();
    temp_msb     = 8'h0C;
    temp_lsb     = 8'h80;
    sample_valid = 1'b1;
    stepCycle();
    temp_msb     = 8'h0F;
    temp_lsb     = 8'h00;
    stepCycle();
    sample_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid === 1'b1) pulses++;
      stepCycle();
    end
    testsRun++; if (pulses !== 1) begin testsFailed++; $display("[TB] FAIL ovr_pulses got %0d want 1", pulses); end
    testsRun++; if (sample_count !== 16'd1) begin testsFailed++; $display("[TB] FAIL ovr_count got %0d want 1", sample_count); end
    testsRun++; if (overrun !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_flag got %b want 1", overrun); end
    testsRun++; if (temp_cur !== 13'd400) begin testsFailed++; $display("[TB] FAIL ovr_temp_cur got %0d want 400", temp_cur); end
    pulseClear();
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovr_cleared got %b want 0", overrun); end
    testsRun++; if ((temp_min !== 13'h0FFF) || (temp_max !== 13'h1000)) begin testsFailed++; $display("[TB] FAIL ovr_minmax_preset got %h/%h want 0FFF/1000", temp_min, temp_max); end
  endtask

  task automatic test_clear_collision();
    int pulses;
    temp_msb     = 8'h0C;
    temp_lsb     = 8'h80;
    sample_valid = 1'b1;
    clear_stats  = 1'b1;
    stepCycle();
    sample_valid = 1'b0;
    clear_stats  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid === 1'b1) pulses++;
      stepCycle();
    end
    testsRun++; if (pulses !== 0) begin testsFailed++; $display("[TB] FAIL clr_collision_pulses got %0d want 0", pulses); end
    testsRun++; if ((overrun !== 1'b0) || (sample_count !== 16'd0)) begin testsFailed++; $display("[TB] FAIL clr_collision_state got ovr=%b cnt=%0d want 0/0", overrun, sample_count); end
  endtask

  task automatic test_back_to_back();
    int   lat1;
    int   lat2;
    logic av;
    applyStimulus(8'h0C, 8'h80, lat1, av);
    applyStimulus(8'hE7, 8'h07, lat2, av);
    testsRun++; if ((lat1 !== 3) || (lat2 !== 3)) begin testsFailed++; $display("[TB] FAIL b2b_latency got %0d/%0d want 3/3", lat1, lat2); end
    testsRun++; if ((sample_count !== 16'd2) || (overrun !== 1'b0)) begin testsFailed++; $display("[TB] FAIL b2b_state got cnt=%0d ovr=%b want 2/0", sample_count, overrun); end
    testsRun++; if (temp_avg !== 13'h1FCE) begin testsFailed++; $display("[TB] FAIL b2b_avg got %h want 1FCE", temp_avg); end
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic av;
    int   pulses;
    alarm_thr = 13'd0;
    applyStimulus(8'h0C, 8'h80, lat, av);
    testsRun++; if (alarm !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_alarm_pre got %b want 1", alarm); end
    temp_msb     = 8'h0F;
    temp_lsb     = 8'h00;
    sample_valid = 1'b1;
    stepCycle();
    sample_valid = 1'b0;
    stepCycle();
    reset = 1'b1;
    stepCycle();
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_out_valid got %b want 0", out_valid); end
    testsRun++; if ((temp_cur !== 13'd0) || (temp_avg !== 13'd0)) begin testsFailed++; $display("[TB] FAIL rstmid_cur_avg got %h/%h want 0/0", temp_cur, temp_avg); end
    testsRun++; if ((temp_min !== 13'h0FFF) || (temp_max !== 13'h1000)) begin testsFailed++; $display("[TB] FAIL rstmid_minmax got %h/%h want 0FFF/1000", temp_min, temp_max); end
    testsRun++; if ({avg_valid, alarm, overrun} !== 3'b000 || sample_count !== 16'd0) begin testsFailed++; $display("[TB] FAIL rstmid_flags got %b cnt=%0d want 000/0", {avg_valid, alarm, overrun}, sample_count); end
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      if (out_valid === 1'b1) pulses++;
    end
    testsRun++; if (pulses !== 0) begin testsFailed++; $display("[TB] FAIL rstmid_no_pulse got %0d want 0", pulses); end
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    clear_stats  = 1'b0;
    temp_msb     = 8'h00;
    temp_lsb     = 8'h00;
    alarm_thr    = 13'd4000;
    alarm_hyst   = 8'd0;
    test_reset();
    test_conversion();
    test_negative();
    test_average();
    test_alarm();
    test_overrun();
    test_clear_collision();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/temp_sample_proc.md
TEMP_SAMPLE_PROC -- requirements
Module: temp_sample_proc

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 3, meaning log2 of the averaging window depth (8 samples).
REQ-002 SHALL have parameter TW, default 13, meaning temperature word width (signed, 1/16 degC per LSB).
REQ-003 SHALL have port FSM_Clk  input  1  the single clock, the I2C FSM clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe: temp_msb/temp_lsb hold a completed sensor read.
REQ-006 SHALL have port temp_msb  input  8  raw sensor MSB byte.
REQ-007 SHALL have port temp_lsb  input  8  raw sensor LSB byte.
REQ-008 SHALL have port clear_stats  input  1  one-cycle strobe: clear the window, min/max, count and overrun.
REQ-009 SHALL have port alarm_thr  input  TW  signed high-temperature alarm threshold.
REQ-010 SHALL have port alarm_hyst  input  8  unsigned alarm hysteresis, in LSBs.
REQ-011 SHALL have port temp_cur  output  TW  latest converted sample, signed.
REQ-012 SHALL have port temp_avg  output  TW  window average, signed.
REQ-013 SHALL have port temp_min / temp_max  output  TW each  extremes since the last clear.
REQ-014 SHALL have port out_valid  output  1  one-cycle pulse: all outputs updated.
REQ-015 SHALL have port avg_valid  output  1  level: the window holds 2^WIN_LOG2 samples.
REQ-016 SHALL have port alarm  output  1  over-temperature flag with hysteresis.
REQ-017 SHALL have port overrun  output  1  sticky flag: a sample was dropped while the block was busy.
REQ-018 SHALL have port sample_count  output  16  count of accepted samples; saturates at 16'hFFFF.

Function
REQ-019 SHALL form temp_cur as {temp_msb, temp_lsb[7:3]}, 13-bit two's complement; temp_lsb[2:0] SHALL be ignored.
REQ-020 SHALL use FSM states IDLE -> CONVERT -> UPDATE -> REPORT -> IDLE, advancing unconditionally one state per cycle after IDLE.
REQ-021 SHALL accept sample_valid only in IDLE; a sample_valid seen at cycle N SHALL produce an out_valid pulse at cycle N+3.
REQ-022 SHALL drop any sample_valid seen outside IDLE, and the drop SHALL set overrun; the state, count and window SHALL remain unchanged.
REQ-023 In UPDATE, the block SHALL write the sample into the circular window at wr_ptr.
REQ-024 The running sum SHALL be updated as sum + new - oldest, in a TW+WIN_LOG2 bit signed value; wr_ptr SHALL wrap from 7 to 0.
REQ-025 SHALL compute temp_avg as the running sum arithmetically shifted right by WIN_LOG2 (floor toward minus infinity).
REQ-026 SHALL set avg_valid in REPORT of the 8th accepted sample after reset or clear.
REQ-027 Before avg_valid, empty window entries SHALL read as zero, and temp_avg SHALL still be driven.
REQ-028 SHALL update temp_min/temp_max in UPDATE using signed compares; the first sample after a clear SHALL load both.
REQ-029 In REPORT, alarm SHALL set when temp_cur >= alarm_thr.
REQ-030 In REPORT, alarm SHALL clear when temp_cur < alarm_thr - alarm_hyst, evaluated at TW+2 bits signed; otherwise alarm SHALL hold.
REQ-031 clear_stats in any state SHALL return the block to IDLE next cycle, with no out_valid.
REQ-032 clear_stats SHALL zero the window, sum, wr_ptr, sample_count, avg_valid and overrun, and SHALL preset min/max; alarm and temp_cur SHALL be kept.
REQ-033 clear_stats and sample_valid in the same cycle: clear SHALL win, the sample SHALL be discarded, and overrun SHALL NOT be set.

Reset
REQ-034 reset SHALL take priority over all inputs and act on the next FSM_Clk edge, from any state including mid-sample.
REQ-035 Reset values SHALL be: state IDLE; temp_cur/temp_avg 0; temp_min 13'h0FFF; temp_max 13'h1000; all flags 0; sample_count 0; window and sum 0.

Structure
REQ-036 A shared package adt7420_pkg SHALL hold the TW and WIN_LOG2 defaults, the state encodings, and the MIN_INIT/MAX_INIT constants.
REQ-037 The window storage SHALL be one sub-module, temp_window_buf, containing 2^WIN_LOG2 x TW registers, the wrap pointer, and the oldest-entry read port.

Verification
REQ-038 Basic conversion: msb=8'h0C, lsb=8'h80 -> temp_cur=400 (25.0 degC), out_valid exactly 3 cycles after sample_valid.
REQ-039 Negative value and extremes: msb=8'hE7, lsb=8'h07 -> temp_cur=-800 (13'h1CE0), flag bits ignored; temp_min=-800.
REQ-040 Window average: 8x value 400 -> avg_valid rises with the 8th out_valid, temp_avg=400; a 9th sample of 480 -> temp_avg=410.
REQ-041 Alarm hysteresis: alarm_thr=480, alarm_hyst=16; samples 480 -> 470 -> 463 give alarm 1, 1, 0.
REQ-042 Overrun: sample_valid at N and N+1 -> one out_valid, sample_count=1, overrun=1; clear_stats -> overrun=0, min/max preset.
REQ-043 Reset mid-operation: reset asserted during UPDATE -> next cycle state IDLE, no out_valid, all outputs at reset values.
